// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh arbiter.
package lcd_pkg;

    // Scanner states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SEND  = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DELAY = 3'd5
    } state_t;

    // Power-up command sequence
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [1:0] INIT_LAST    = 2'd3;

    // DDRAM position bases and the blank character
    localparam logic [7:0] POS_LINE1  = 8'h80;
    localparam logic [7:0] POS_LINE2  = 8'hC0;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Command byte for a given init step
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            2'd3:    cmd = CMD_ENTRY;
            default: cmd = CMD_FUNC_SET;
        endcase
        return cmd;
    endfunction

    // Set-DDRAM-address command for a cell index (0-15 line 1, 16-31 line 2)
    function automatic logic [7:0] pos_cmd(input logic [4:0] idx);
        logic [7:0] cmd;
        if (idx[4]) begin
            cmd = POS_LINE2 | {4'h0, idx[3:0]};
        end else begin
            cmd = POS_LINE1 | {4'h0, idx[3:0]};
        end
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
module lcd_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    logic last1_r;  // 1 = requester 1 was granted most recently

    // Combinational grant from current requests and grant history
    always_comb begin
        ready0 = valid0 && (!valid1 || last1_r);
        ready1 = valid1 && (!valid0 || !last1_r);
    end

    // History moves only when a write is actually accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            last1_r <= 1'b1;
        end else if (ready0 || ready1) begin
            last1_r <= ready1;
        end
    end

endmodule

// File: rtl/lcd_refresh_arbiter.sv
// Frame-buffered LCD refresher: two writers fill a 32-cell buffer, the
// scanner streams dirty cells to a byte controller with minimal cursor moves.
module lcd_refresh_arbiter
    import lcd_pkg::*;
#(
    parameter logic [17:0] DLY_MAX = 18'h3FFFE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0_VALID,
    input  logic [4:0] REQ0_ADDR,
    input  logic [7:0] REQ0_CHAR,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [4:0] REQ1_ADDR,
    input  logic [7:0] REQ1_CHAR,
    output logic       REQ1_READY,
    output logic [7:0] LCD_DATA_O,
    output logic       LCD_RS_O,
    output logic       LCD_START,
    input  logic       LCD_DONE,
    output logic       INIT_DONE,
    output logic       BUSY
);

    state_t      state_r, state_n;
    logic [1:0]  step_r;
    logic        init_done_r;
    logic [17:0] cnt_r;
    logic [4:0]  sel_r;
    logic        phase_char_r;   // 1 = next byte for sel_r is the character
    logic [4:0]  cursor_r;
    logic        cursor_valid_r;
    logic [4:0]  last_sent_r;
    logic        lcd_start_r;
    logic [7:0]  data_r;
    logic        rs_r;
    logic [7:0]  fb_r [32];
    logic [31:0] dirty_r;

    logic        wr_en_s;
    logic [4:0]  wr_addr_s;
    logic [7:0]  wr_char_s;
    logic        found_s;
    logic [4:0]  scan_idx_s;
    logic [4:0]  probe_s;
    logic        dly_end_s;
    logic        char_send_s;
    logic [7:0]  send_byte_s;
    logic        send_rs_s;

    lcd_rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .valid0 (REQ0_VALID),
        .valid1 (REQ1_VALID),
        .ready0 (REQ0_READY),
        .ready1 (REQ1_READY)
    );

    // Select the granted requester's write
    always_comb begin
        wr_en_s = REQ0_READY || REQ1_READY;
        if (REQ1_READY) begin
            wr_addr_s = REQ1_ADDR;
            wr_char_s = REQ1_CHAR;
        end else begin
            wr_addr_s = REQ0_ADDR;
            wr_char_s = REQ0_CHAR;
        end
    end

    // Find the first dirty cell at or after last_sent+1, wrapping
    always_comb begin
        found_s    = 1'b0;
        scan_idx_s = 5'd0;
        probe_s    = 5'd0;
        for (int k = 0; k < 32; k++) begin
            probe_s = last_sent_r + 5'd1 + 5'(k);
            if (!found_s && dirty_r[probe_s]) begin
                found_s    = 1'b1;
                scan_idx_s = probe_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Byte to launch in SEND and related strobes
    always_comb begin
        dly_end_s   = ({1'b0, cnt_r} + 19'd1) >= {1'b0, DLY_MAX};
        char_send_s = (state_r == ST_SEND) && init_done_r && phase_char_r;
        if (!init_done_r) begin
            send_byte_s = init_cmd(step_r);
            send_rs_s   = 1'b0;
        end else if (phase_char_r) begin
            send_byte_s = fb_r[sel_r];
            send_rs_s   = 1'b1;
        end else begin
            send_byte_s = pos_cmd(sel_r);
            send_rs_s   = 1'b0;
        end
    end

    // Scanner next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_INIT:  state_n = ST_SEND;
            ST_IDLE:  state_n = found_s ? ST_SEND : ST_IDLE;
            ST_SEND:  state_n = ST_ARM;
            ST_ARM:   state_n = ST_WAIT;
            ST_WAIT:  state_n = LCD_DONE ? ST_DELAY : ST_WAIT;
            ST_DELAY: begin
                if (!dly_end_s) begin
                    state_n = ST_DELAY;
                end else if (!init_done_r) begin
                    state_n = (step_r == INIT_LAST) ? ST_IDLE : ST_INIT;
                end else if (!phase_char_r) begin
                    state_n = ST_SEND;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default:  state_n = ST_INIT;
        endcase
    end

    // Scanner state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_n;
        end
    end

    // Transfer handshake, delay counter, cursor tracking and init progress
    always_ff @(posedge CLK) begin
        if (RST) begin
            step_r         <= 2'd0;
            init_done_r    <= 1'b0;
            cnt_r          <= 18'd0;
            sel_r          <= 5'd0;
            phase_char_r   <= 1'b0;
            cursor_r       <= 5'd0;
            cursor_valid_r <= 1'b0;
            last_sent_r    <= 5'd31;
            lcd_start_r    <= 1'b0;
            data_r         <= 8'h00;
            rs_r           <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        sel_r        <= scan_idx_s;
                        phase_char_r <= cursor_valid_r && (cursor_r == scan_idx_s);
                    end
                end
                ST_SEND: begin
                    lcd_start_r <= 1'b1;
                    data_r      <= send_byte_s;
                    rs_r        <= send_rs_s;
                    if (char_send_s) begin
                        last_sent_r    <= sel_r;
                        cursor_r       <= sel_r + 5'd1;
                        cursor_valid_r <= (sel_r[3:0] != 4'hF);
                    end
                end
                ST_WAIT: begin
                    if (LCD_DONE) begin
                        lcd_start_r <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (dly_end_s) begin
                        cnt_r <= 18'd0;
                        if (!init_done_r) begin
                            step_r <= step_r + 2'd1;
                            if (step_r == INIT_LAST) begin
                                init_done_r <= 1'b1;
                            end
                        end else if (!phase_char_r) begin
                            phase_char_r   <= 1'b1;
                            cursor_r       <= sel_r;
                            cursor_valid_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 18'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame buffer and dirty bits; a same-edge write beats the clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                fb_r[i] <= BLANK_CHAR;
            end
            dirty_r <= 32'hFFFF_FFFF;
        end else begin
            if (char_send_s) begin
                dirty_r[sel_r] <= 1'b0;
            end
            if (wr_en_s) begin
                fb_r[wr_addr_s]    <= wr_char_s;
                dirty_r[wr_addr_s] <= 1'b1;
            end
        end
    end

    assign LCD_START  = lcd_start_r;
    assign LCD_DATA_O = data_r;
    assign LCD_RS_O   = rs_r;
    assign INIT_DONE  = init_done_r;
    assign BUSY       = (state_r != ST_IDLE) || (|dirty_r);

endmodule

// File: tb/tb_lcd_refresh_arbiter.sv
// Bench for lcd_refresh_arbiter: model byte controller, behavioural
// reference of the expected byte stream and grants, directed scenarios.
module tb_lcd_refresh_arbiter;

    logic       CLK, RST;
    logic       REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
    logic [4:0] REQ0_ADDR, REQ1_ADDR;
    logic [7:0] REQ0_CHAR, REQ1_CHAR;
    logic [7:0] LCD_DATA_O;
    logic       LCD_RS_O, LCD_START, LCD_DONE, INIT_DONE, BUSY;

    int tests = 0;
    int fails = 0;

    lcd_refresh_arbiter #(.DLY_MAX(18'd4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_CHAR(REQ0_CHAR), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_CHAR(REQ1_CHAR), .REQ1_READY(REQ1_READY),
        .LCD_DATA_O(LCD_DATA_O), .LCD_RS_O(LCD_RS_O), .LCD_START(LCD_START), .LCD_DONE(LCD_DONE),
        .INIT_DONE(INIT_DONE), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: condition not reached", name);
    endtask

    // Model byte controller: drops DONE on START rise, raises it 20 cycles later
    int   dcnt = 0;
    logic start_seen = 1'b0;
    always @(posedge CLK) begin
        #2;
        if (LCD_START && !start_seen) begin
            start_seen = 1'b1;
            LCD_DONE   = 1'b0;
            dcnt       = 20;
        end else if (!LCD_START) begin
            start_seen = 1'b0;
        end
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) LCD_DONE = 1'b1;
        end
    end

    // Behavioural reference state
    logic [7:0]  mbuf [32];
    logic        mdirty [32];
    logic [7:0]  init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int          m_init, m_post;
    logic        m_pend, m_cur_v, m_hist, m_live;
    logic [4:0]  m_sel, m_cur, m_last, m_idx;
    logic        m_found, m_any;
    logic [8:0]  m_exp;
    logic        wp_valid, rst_pend, start_prev, rs_prev;
    logic [4:0]  wp_addr;
    logic [7:0]  wp_char, data_prev;
    logic        e0, e1;
    logic [8:0]  log_q [$];

    initial begin
        m_live   = 1'b0;
        rst_pend = 1'b0;
        wp_valid = 1'b0;
    end

    // Compare process: every falling edge, check DUT against the reference
    always @(negedge CLK) begin
        if (rst_pend) begin
            m_live = 1'b1;
            for (int i = 0; i < 32; i++) begin
                mbuf[i]   = 8'h20;
                mdirty[i] = 1'b1;
            end
            m_init = 0; m_post = 0; m_pend = 1'b0; m_cur_v = 1'b0;
            m_last = 5'd31; m_hist = 1'b1;
            check("rst_start", LCD_START, 1'b0);
            check("rst_data", LCD_DATA_O, 8'h00);
            check("rst_rs", LCD_RS_O, 1'b0);
            check("rst_init_done", INIT_DONE, 1'b0);
            check("rst_busy", BUSY, 1'b1);
            start_prev = 1'b0;
        end else if (m_live) begin
            if (LCD_START && !start_prev) begin
                if (m_init < 4) begin
                    m_exp = {1'b0, init_tab[m_init]};
                    m_init++;
                end else begin
                    m_post++;
                    if (!m_pend) begin
                        m_found = 1'b0;
                        m_idx   = 5'd0;
                        for (int k = 1; k <= 32; k++) begin
                            if (!m_found && mdirty[(m_last + k) % 32]) begin
                                m_found = 1'b1;
                                m_idx   = 5'((m_last + k) % 32);
                            end
                        end
                        if (!m_found) fail_now("spurious_transfer");
                        m_sel = m_idx;
                        if (!(m_cur_v && m_cur == m_idx)) begin
                            m_pend = 1'b1;
                            m_exp  = (m_idx < 16) ? {1'b0, 8'h80 + 8'(m_idx)}
                                                  : {1'b0, 8'hC0 + 8'(m_idx - 16)};
                        end
                    end else begin
                        m_pend = 1'b0;
                    end
                    if (!m_pend) begin
                        m_exp          = {1'b1, mbuf[m_sel]};
                        mdirty[m_sel]  = 1'b0;
                        m_last         = m_sel;
                        m_cur          = m_sel + 5'd1;
                        m_cur_v        = (m_sel != 5'd15) && (m_sel != 5'd31);
                    end
                end
                check("lcd_byte", {LCD_RS_O, LCD_DATA_O}, m_exp);
                log_q.push_back({LCD_RS_O, LCD_DATA_O});
            end else if (LCD_START && start_prev) begin
                check("hold_data", LCD_DATA_O, data_prev);
                check("hold_rs", LCD_RS_O, rs_prev);
            end
            if (wp_valid) begin
                mbuf[wp_addr]   = wp_char;
                mdirty[wp_addr] = 1'b1;
            end
            if (m_post > 0) check("init_done_hi", INIT_DONE, 1'b1);
            else if (m_init < 4) check("init_done_lo", INIT_DONE, 1'b0);
            m_any = 1'b0;
            for (int i = 0; i < 32; i++) m_any = m_any | mdirty[i];
            if (m_any) check("busy_dirty", BUSY, 1'b1);
            start_prev = LCD_START;
        end
        data_prev = LCD_DATA_O;
        rs_prev   = LCD_RS_O;
        wp_valid  = 1'b0;
        rst_pend  = RST;
        if (!RST && m_live) begin
            e0 = REQ0_VALID && (!REQ1_VALID || m_hist);
            e1 = REQ1_VALID && (!REQ0_VALID || !m_hist);
            check("ready0", REQ0_READY, e0);
            check("ready1", REQ1_READY, e1);
            if (e0 || e1) begin
                wp_valid = 1'b1;
                wp_addr  = e1 ? REQ1_ADDR : REQ0_ADDR;
                wp_char  = e1 ? REQ1_CHAR : REQ0_CHAR;
                m_hist   = e1;
            end
        end
    end

    task automatic write0(input logic [4:0] a, input logic [7:0] c);
        @(posedge CLK); #2;
        REQ0_VALID = 1'b1; REQ0_ADDR = a; REQ0_CHAR = c;
        @(posedge CLK); #2;
        REQ0_VALID = 1'b0;
    endtask

    task automatic write0_pair(input logic [4:0] a1, input logic [7:0] c1,
                               input logic [4:0] a2, input logic [7:0] c2);
        @(posedge CLK); #2;
        REQ0_VALID = 1'b1; REQ0_ADDR = a1; REQ0_CHAR = c1;
        @(posedge CLK); #2;
        REQ0_ADDR = a2; REQ0_CHAR = c2;
        @(posedge CLK); #2;
        REQ0_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int good = 0;
        int n    = 0;
        while (good < 3 && n < 4000) begin
            @(negedge CLK);
            n++;
            if (BUSY === 1'b0 && INIT_DONE === 1'b1 && LCD_START === 1'b0) good++;
            else good = 0;
        end
        if (good < 3) fail_now(name);
    endtask

    task automatic check_log(input string name, input int idx, input logic [8:0] exp);
        if (idx < log_q.size()) check(name, log_q[idx], exp);
        else fail_now(name);
    endtask

    int base, bad;
    logic [3:0] r1_seq;

    initial begin
        RST = 1'b1; LCD_DONE = 1'b1;
        REQ0_VALID = 1'b0; REQ0_ADDR = 5'd0; REQ0_CHAR = 8'h00;
        REQ1_VALID = 1'b0; REQ1_ADDR = 5'd0; REQ1_CHAR = 8'h00;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_start", LCD_START, 1'b0);
        check("post_rst_init_done", INIT_DONE, 1'b0);

        // Power-up: init commands then a full blank paint
        wait_idle("idle_after_init");
        check("n_init_bytes", log_q.size(), 38);
        check_log("init0", 0, 9'h038);
        check_log("init1", 1, 9'h00C);
        check_log("init2", 2, 9'h001);
        check_log("init3", 3, 9'h006);
        check_log("pos_line1", 4, 9'h080);
        check_log("blank0", 5, 9'h120);
        check_log("blank15", 20, 9'h120);
        check_log("pos_line2", 21, 9'h0C0);
        check_log("blank31", 37, 9'h120);
        check("init_done", INIT_DONE, 1'b1);
        check("busy_idle", BUSY, 1'b0);

        // Both requesters contending for four cycles
        base = log_q.size();
        begin
            logic [4:0] a0 [2] = '{5'd3, 5'd5};
            logic [7:0] c0 [2] = '{8'h61, 8'h63};
            logic [4:0] a1 [2] = '{5'd4, 5'd6};
            logic [7:0] c1 [2] = '{8'h62, 8'h64};
            int i0 = 0;
            int i1 = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge CLK); #2;
                REQ0_VALID = (i0 < 2); REQ0_ADDR = a0[i0 % 2]; REQ0_CHAR = c0[i0 % 2];
                REQ1_VALID = (i1 < 2); REQ1_ADDR = a1[i1 % 2]; REQ1_CHAR = c1[i1 % 2];
                @(negedge CLK);
                r1_seq[k] = REQ1_READY;
                if (REQ0_READY) i0++;
                if (REQ1_READY) i1++;
            end
            @(posedge CLK); #2;
            REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        end
        check("ready1_alternates", r1_seq, 4'b1010);
        wait_idle("idle_after_contend");
        check("n_contend", log_q.size() - base, 5);
        check_log("c_pos", base + 0, 9'h083);
        check_log("c_a", base + 1, 9'h161);
        check_log("c_b", base + 2, 9'h162);
        check_log("c_c", base + 3, 9'h163);
        check_log("c_d", base + 4, 9'h164);

        // Single write to a line-2 cell
        base = log_q.size();
        write0(5'd20, 8'h41);
        wait_idle("idle_after_c20");
        check("n_c20", log_q.size() - base, 2);
        check_log("c20_pos", base + 0, 9'h0C4);
        check_log("c20_chr", base + 1, 9'h141);

        // Adjacent cells share one position command; line wrap needs a new one
        base = log_q.size();
        write0_pair(5'd7, 8'h41, 5'd8, 8'h42);
        wait_idle("idle_after_c78");
        check("n_c78", log_q.size() - base, 3);
        check_log("c78_pos", base + 0, 9'h087);
        check_log("c7_chr", base + 1, 9'h141);
        check_log("c8_chr", base + 2, 9'h142);
        base = log_q.size();
        write0_pair(5'd15, 8'h58, 5'd16, 8'h59);
        wait_idle("idle_after_c1516");
        check("n_c1516", log_q.size() - base, 4);
        check_log("c15_pos", base + 0, 9'h08F);
        check_log("c15_chr", base + 1, 9'h158);
        check_log("c16_pos", base + 2, 9'h0C0);
        check_log("c16_chr", base + 3, 9'h159);

        // Rewrite cell 2 on the very edge its character is launched
        base = log_q.size();
        write0(5'd2, 8'h50);
        begin
            int n = 0;
            while (!(LCD_START === 1'b1 && LCD_RS_O === 1'b0 && LCD_DATA_O === 8'h82) && n < 500) begin
                @(negedge CLK); n++;
            end
            if (n >= 500) fail_now("wait_pos2");
            n = 0;
            while (!(LCD_START === 1'b1 && LCD_DONE === 1'b1) && n < 500) begin
                @(negedge CLK); n++;
            end
            if (n >= 500) fail_now("wait_done_pos2");
        end
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        #2 REQ0_VALID = 1'b1; REQ0_ADDR = 5'd2; REQ0_CHAR = 8'h51;
        @(posedge CLK);
        #2 REQ0_VALID = 1'b0;
        wait_idle("idle_after_c2");
        check("n_c2", log_q.size() - base, 4);
        check_log("c2_pos_a", base + 0, 9'h082);
        check_log("c2_old", base + 1, 9'h150);
        check_log("c2_pos_b", base + 2, 9'h082);
        check_log("c2_new", base + 3, 9'h151);

        // Reset while waiting on the byte controller
        write0(5'd10, 8'h5A);
        begin
            int n = 0;
            while (LCD_START !== 1'b1 && n < 500) begin
                @(negedge CLK); n++;
            end
            if (n >= 500) fail_now("wait_c10_start");
        end
        repeat (5) @(negedge CLK);
        check("in_wait_start", LCD_START, 1'b1);
        @(posedge CLK); #2 RST = 1'b1;
        @(posedge CLK); #2 RST = 1'b0;
        @(negedge CLK);
        check("rst_wait_start", LCD_START, 1'b0);
        check("rst_wait_init_done", INIT_DONE, 1'b0);
        base = log_q.size();
        wait_idle("idle_after_rst");
        check("n_repaint", log_q.size() - base, 38);
        check_log("re_init0", base + 0, 9'h038);
        check_log("re_pos1", base + 4, 9'h080);
        check_log("re_pos2", base + 21, 9'h0C0);
        bad = 0;
        for (int i = 0; i < 34; i++) begin
            if (base + 4 + i < log_q.size() && i != 0 && i != 17 && log_q[base + 4 + i] !== 9'h120) bad++;
        end
        check("repaint_blank", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lcd_refresh_arbiter.md
LCD_REFRESH_ARBITER -- requirements
Module: lcd_refresh_arbiter

Interface
REQ-001 Parameter DLY_MAX, default 18'h3FFFE: idle cycles inserted after every completed LCD byte transfer.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REQ0_VALID  in  1  requester 0 write request.
REQ-005 REQ0_ADDR  in  5  character cell 0-15 line 1, 16-31 line 2.
REQ-006 REQ0_CHAR  in  8  ASCII code.
REQ-007 REQ0_READY  out  1  requester 0 write accepted this cycle.
REQ-008 REQ1_VALID / REQ1_ADDR / REQ1_CHAR / REQ1_READY: identical to REQ-004..007 for requester 1.
REQ-009 LCD_DATA_O  out  8  byte to the LCD byte controller.
REQ-010 LCD_RS_O  out  1  0 = command, 1 = data.
REQ-011 LCD_START  out  1  transfer request to the byte controller.
REQ-012 LCD_DONE  in  1  byte controller completion; stays high until the controller sees the next START rise.
REQ-013 INIT_DONE  out  1  high once the init sequence has completed.
REQ-014 BUSY  out  1  high when state is not IDLE or any dirty bit is set.

Function
REQ-015 The block SHALL hold a 32x8 frame buffer and a 32-bit dirty vector.
REQ-016 A write SHALL be accepted only on VALID&READY; it updates the buffer and sets the dirty bit in that same edge; writes are accepted in every state, INIT included.
REQ-017 READY SHALL be combinational: only one requester valid -> that requester is granted; both valid -> the one not granted last; grant history updates only on an accepted write.
REQ-018 The scanner SHALL use these states: INIT, IDLE, SEND, ARM, WAIT, DELAY.
REQ-019 INIT SHALL issue the commands 0x38, 0x0C, 0x01, 0x06 in order, each through SEND/ARM/WAIT/DELAY. INIT_DONE SHALL rise in the cycle after the last DELAY ends.
REQ-020 IDLE SHALL select the first dirty index at or after (last_sent+1) mod 32, wrapping; SEND SHALL follow in the next cycle.
REQ-021 If the tracked cursor is not equal to the selected index, the block SHALL send a position command first: 0x80|i for i<16, 0xC0|(i-16) otherwise.
REQ-022 After the position command, the block SHALL send the character byte with RS=1.
REQ-023 The dirty bit SHALL be cleared on the SEND edge of the character byte; a write to the same cell on that same edge SHALL leave the bit set (set wins).
REQ-024 After a character is written, the cursor SHALL advance to i+1. After index 15 or 31, the cursor SHALL become invalid and the next character requires a position command.
REQ-025 In SEND, LCD_START SHALL rise with DATA_O and RS_O; all three SHALL be held stable until WAIT ends.
REQ-026 ARM SHALL last exactly 1 cycle, with LCD_DONE ignored, so that a stale DONE is never taken as completion.
REQ-027 WAIT SHALL exit on LCD_DONE=1 and drop LCD_START on that edge.
REQ-028 DELAY SHALL count DLY_MAX cycles, then go to the next INIT step or to IDLE.
REQ-029 WAIT SHALL have no timeout; a DONE that never arrives stalls the scanner while writes are still accepted.

Reset
REQ-030 On RST, the following SHALL apply: state=INIT (step 0); LCD_START=0, DATA_O=0, RS_O=0, INIT_DONE=0; delay counter=0; cursor invalid; last_sent=31; grant history=requester 1 (requester 0 wins the first tie).
REQ-031 On RST, all buffer entries SHALL be set to 0x20 and all 32 dirty bits set, so the first refresh paints the full screen.
REQ-032 RST asserted mid-transfer SHALL take priority over every other action in that cycle.

Structure
REQ-033 Package lcd_pkg SHALL hold the state enum, the init command constants, position bases 0x80/0xC0 and the blank char 0x20.
REQ-034 The 2-way round-robin grant SHALL be a sub-module, lcd_rr_arb2.

Verification
REQ-035 Reset with DLY_MAX=4 and a model controller (DONE 20 cycles after START) -> bytes 0x38, 0x0C, 0x01, 0x06, then 0x80 and 16x0x20, then 0xC0 and 16x0x20; INIT_DONE=1; BUSY=0.
REQ-036 Both requesters valid for 4 cycles (addresses 3, 4, 5, 6) -> READY alternates 0,1,0,1; buffer holds all four chars.
REQ-037 After idle, write 'A' to cell 20 -> exactly two bytes: 0xC4 (RS=0), then 0x41 (RS=1).
REQ-038 Write cells 7 and 8 back-to-back -> 0x87, 0x41, 0x42 (no second position command); cells 15 and 16 -> 0x8F, char, 0xC0, char.
REQ-039 Rewrite cell 2 on the same edge its char byte is sent -> cell 2 is sent again with the new value.
REQ-040 RST pulsed while in WAIT -> LCD_START=0 next cycle; init restarts at 0x38; buffer all 0x20.
